// File: rtl/axis_tx_arbiter_pkg.sv
// Shared types and constants for the TX stream arbiter and its round-robin picker.
// No logic here; state encoding, index-width helper and the injected abort beat.
// No backpressure concerns; consumed by axis_tx_arbiter and rr_pick users.
package axis_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  function automatic int port_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Beat presented to the MAC when a stalled frame is cut short.
  localparam logic [7:0] ABORT_TDATA     = 8'h00;
  localparam logic       ABORT_TLAST     = 1'b1;
  localparam logic       ABORT_TUSER_BIT = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request strictly after ptr, wrapping.
// Zero latency; purely combinational.
// No backpressure; caller decides when to act on the winner.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  int             start;
  int             enc;

  always_comb begin
    req_dbl = {req, req};
    start   = (int'(ptr) + 1) % N;
    // Rotate so the highest-priority candidate lands on bit 0.
    req_rot = req_dbl[start +: N];
    enc     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) enc = i;
    end
    winner  = IDX_W'((enc + start) % N);
    any_req = |req;
  end

endmodule

// File: rtl/axis_tx_arbiter.sv
// Packet-granular round-robin mux of NUM_PORTS byte streams onto one MAC TX stream; stall abort via AXIS_TX_ARBITER_TIMEOUT_EN.
// Latency: one cycle from first tvalid to m_axis_tvalid; one idle cycle between frames.
// Backpressure: m_axis_tready passes straight to the granted port only; grant held until tlast.
module axis_tx_arbiter
  import axis_tx_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int USER_WIDTH = 1
`ifdef AXIS_TX_ARBITER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS*8-1:0]              s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                s_axis_tready,
  input  logic [NUM_PORTS-1:0]                s_axis_tlast,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]     s_axis_tuser,
  output logic [7:0]                          m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic [USER_WIDTH-1:0]               m_axis_tuser,
  output logic [port_idx_w(NUM_PORTS)-1:0]    grant_idx,
  output logic                                busy,
  output logic [NUM_PORTS-1:0]                pkt_done
`ifdef AXIS_TX_ARBITER_TIMEOUT_EN
  , output logic [15:0]                       abort_cnt
`endif
);

  localparam int IDX_W = port_idx_w(NUM_PORTS);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             any_req;
  int               sel;
  logic             sel_vld;
  logic             sel_last;

`ifdef AXIS_TX_ARBITER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;
`endif

  rr_pick #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (s_axis_tvalid),
    .ptr     (rr_ptr),
    .winner  (pick_idx),
    .any_req (any_req)
  );

  assign busy = (state == XFER) || (state == DRAIN);

  always_comb begin
    sel           = int'(grant_idx);
    sel_vld       = s_axis_tvalid[sel];
    sel_last      = s_axis_tlast[sel];
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    case (state)
      XFER: begin
        m_axis_tdata       = s_axis_tdata[sel*8 +: 8];
        m_axis_tvalid      = sel_vld;
        m_axis_tlast       = sel_last;
        m_axis_tuser       = s_axis_tuser[sel*USER_WIDTH +: USER_WIDTH];
        s_axis_tready[sel] = m_axis_tready;
      end
`ifdef AXIS_TX_ARBITER_TIMEOUT_EN
      ABORT: begin
        m_axis_tdata  = ABORT_TDATA;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = ABORT_TLAST;
        m_axis_tuser  = {USER_WIDTH{ABORT_TUSER_BIT}};
      end
      DRAIN: s_axis_tready[sel] = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= IDX_W'(NUM_PORTS - 1);
      grant_idx <= '0;
      pkt_done  <= '0;
`ifdef AXIS_TX_ARBITER_TIMEOUT_EN
      stall_cnt <= '0;
      abort_cnt <= '0;
`endif
    end else begin
      pkt_done <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_idx <= pick_idx;
            state     <= XFER;
`ifdef AXIS_TX_ARBITER_TIMEOUT_EN
            stall_cnt <= '0;
`endif
          end
        end
        XFER: begin
          if (sel_vld && m_axis_tready) begin
`ifdef AXIS_TX_ARBITER_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (sel_last) begin
              pkt_done[grant_idx] <= 1'b1;
              rr_ptr              <= grant_idx;
              state               <= IDLE;
            end
          end
`ifdef AXIS_TX_ARBITER_TIMEOUT_EN
          // MAC backpressure is not a source stall; only missing tvalid counts.
          else if (!sel_vld) begin
            if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
              state <= ABORT;
              if (abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
            end else begin
              stall_cnt <= stall_cnt + STALL_W'(1);
            end
          end
`endif
        end
`ifdef AXIS_TX_ARBITER_TIMEOUT_EN
        ABORT: begin
          if (m_axis_tready) state <= DRAIN;
        end
        DRAIN: begin
          if (sel_vld && sel_last) begin
            rr_ptr <= grant_idx;
            state  <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Directed bench for axis_tx_arbiter with per-port frame sources and a beat recorder.
module tb_axis_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tvalid;
  logic [3:0]  s_axis_tready;
  logic [3:0]  s_axis_tlast;
  logic [3:0]  s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic [1:0]  grant_idx;
  logic        busy;
  logic [3:0]  pkt_done;
`ifdef AXIS_TX_ARBITER_TIMEOUT_EN
  logic [15:0] abort_cnt;
`endif

  axis_tx_arbiter #(.NUM_PORTS(4), .USER_WIDTH(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .pkt_done      (pkt_done)
`ifdef AXIS_TX_ARBITER_TIMEOUT_EN
    , .abort_cnt   (abort_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Source state per port.
  int   nfrm[4];
  int   flen[4];
  int   frm[4];
  int   bidx[4];
  bit [3:0] en;
  bit [3:0] hold;
  bit   tog;
  int   cyc = 0;

  // Recorder.
  logic [7:0] b_dat[$];
  logic       b_last[$];
  logic       b_user[$];
  int         b_cyc[$];
  int         g_code;
  int         d_code;
  logic [3:0] rdy_seen;
  int         mirror_bad;
  bit         pkt_start;
  bit         inj_seen;

  function automatic logic [7:0] dat(input int p, input int f, input int b);
    return 8'((b * 3 + f * 37 + p * 101 + 5) % 256);
  endfunction

  task automatic setup_src(input int p, input int n, input int len);
    nfrm[p] = n; flen[p] = len; frm[p] = 0; bidx[p] = 0; en[p] = 1'b1; hold[p] = 1'b0;
  endtask

  task automatic clear_mon();
    b_dat.delete(); b_last.delete(); b_user.delete(); b_cyc.delete();
    g_code = 0; d_code = 0; rdy_seen = '0; mirror_bad = 0; pkt_start = 1'b1; inj_seen = 1'b0;
  endtask

  // One cycle: drive at negedge, observe 1ns later, advance sources on accepted beats.
  task automatic step();
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      s_axis_tvalid[p]       = en[p] && !hold[p] && (frm[p] < nfrm[p]);
      s_axis_tdata[p*8 +: 8] = dat(p, frm[p], bidx[p]);
      s_axis_tlast[p]        = (bidx[p] == flen[p] - 1);
    end
    s_axis_tuser  = '0;
    m_axis_tready = tog ? (cyc % 2 == 0) : 1'b1;
    #1;
    if (m_axis_tvalid && m_axis_tready) begin
      b_dat.push_back(m_axis_tdata);
      b_last.push_back(m_axis_tlast);
      b_user.push_back(m_axis_tuser[0]);
      b_cyc.push_back(cyc);
      if (pkt_start) g_code = (g_code << 4) | (int'(grant_idx) + 1);
      pkt_start = m_axis_tlast;
      if (m_axis_tuser[0]) inj_seen = 1'b1;
    end
    for (int p = 0; p < 4; p++)
      if (pkt_done[p]) d_code = (d_code << 4) | (p + 1);
    rdy_seen = rdy_seen | s_axis_tready;
    if (tog && busy && (s_axis_tready[3] !== m_axis_tready)) mirror_bad++;
    for (int p = 0; p < 4; p++) begin
      if (s_axis_tvalid[p] && s_axis_tready[p]) begin
        if (bidx[p] == flen[p] - 1) begin
          bidx[p] = 0;
          frm[p]++;
        end else begin
          bidx[p]++;
        end
      end
    end
    cyc++;
  endtask

  // Counts beats that differ from the expected frame sequence (data, tlast, tuser, count).
  function automatic int stream_errs(input int ports[$], input int len);
    int errs = 0;
    int k = 0;
    int fr[4] = '{default: 0};
    foreach (ports[i]) begin
      for (int b = 0; b < len; b++) begin
        if (k >= b_dat.size()) errs++;
        else if (b_dat[k] !== dat(ports[i], fr[ports[i]], b) ||
                 b_last[k] !== (b == len - 1) || b_user[k] !== 1'b0) errs++;
        k++;
      end
      fr[ports[i]]++;
    end
    if (b_dat.size() > k) errs += b_dat.size() - k;
    return errs;
  endfunction

  // Beats within a frame must be consecutive; exactly one bubble between frames.
  function automatic int gap_errs(input int len);
    int errs = 0;
    for (int k = 1; k < b_cyc.size(); k++)
      if (b_cyc[k] - b_cyc[k-1] != ((k % len == 0) ? 2 : 1)) errs++;
    return errs;
  endfunction

  task automatic test_reset();
    logic [31:0] outs;
    rst = 1'b0; tog = 1'b0; en = '0; hold = '0;
    for (int p = 0; p < 4; p++) begin nfrm[p] = 0; flen[p] = 1; frm[p] = 0; bidx[p] = 0; end
    m_axis_tready = 1'b0; s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tlast = '0; s_axis_tuser = '0;
    #3;
    n_chk++;
    if (grant_idx !== 2'd0) $display("FAIL reset_grant_idx got %0d want 0", grant_idx);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0 || s_axis_tready !== 4'd0) $display("FAIL reset_busy_rdy got busy=%b rdy=%b want 0/0000", busy, s_axis_tready);
    else n_pass++;
    outs = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, pkt_done};
    n_chk++;
    if (outs !== 32'd0) $display("FAIL reset_m_axis got %h want 0", outs);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    int exp[$];
    clear_mon();
    for (int p = 0; p < 4; p++) setup_src(p, 2, 64);
    for (int c = 0; c < 1000 && d_code < 32'h10000000; c++) step();
    exp = {0, 1, 2, 3, 0, 1, 2, 3};
    n_chk++;
    if (g_code !== 32'h12341234) $display("FAIL rr_grant_order got %h want 12341234", g_code);
    else n_pass++;
    n_chk++;
    if (d_code !== 32'h12341234) $display("FAIL rr_pkt_done_order got %h want 12341234", d_code);
    else n_pass++;
    n_chk++;
    if (stream_errs(exp, 64) !== 0) $display("FAIL rr_stream got %0d bad beats want 0", stream_errs(exp, 64));
    else n_pass++;
    n_chk++;
    if (gap_errs(64) !== 0) $display("FAIL rr_gaps got %0d bad gaps want 0", gap_errs(64));
    else n_pass++;
  endtask

  task automatic test_single();
    int exp[$];
    clear_mon();
    for (int p = 0; p < 4; p++) setup_src(p, 0, 64);
    setup_src(2, 3, 60);
    for (int c = 0; c < 400 && d_code < 32'h100; c++) step();
    exp = {2, 2, 2};
    n_chk++;
    if (g_code !== 32'h333 || d_code !== 32'h333) $display("FAIL single_grants got g=%h d=%h want 333/333", g_code, d_code);
    else n_pass++;
    n_chk++;
    if (stream_errs(exp, 60) !== 0 || gap_errs(60) !== 0) $display("FAIL single_stream got %0d bad beats %0d bad gaps want 0/0", stream_errs(exp, 60), gap_errs(60));
    else n_pass++;
    n_chk++;
    if ((rdy_seen & 4'b1011) !== 4'd0) $display("FAIL single_other_rdy got %b want 0000 on ports 0/1/3", rdy_seen & 4'b1011);
    else n_pass++;
  endtask

  task automatic test_late_requester();
    int exp[$];
    clear_mon();
    for (int p = 0; p < 4; p++) setup_src(p, 0, 64);
    setup_src(1, 1, 64);
    setup_src(0, 1, 64);
    en[0] = 1'b0;
    for (int c = 0; c < 400 && d_code < 32'h10; c++) begin
      if (bidx[1] >= 10 || frm[1] > 0) en[0] = 1'b1;
      step();
    end
    exp = {1, 0};
    n_chk++;
    if (g_code !== 32'h21 || d_code !== 32'h21) $display("FAIL late_grants got g=%h d=%h want 21/21", g_code, d_code);
    else n_pass++;
    n_chk++;
    if (stream_errs(exp, 64) !== 0 || gap_errs(64) !== 0) $display("FAIL late_stream got %0d bad beats %0d bad gaps want 0/0", stream_errs(exp, 64), gap_errs(64));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int exp[$];
    logic [31:0] outs;
    clear_mon();
    for (int p = 0; p < 4; p++) setup_src(p, 0, 64);
    setup_src(1, 1, 64);
    for (int c = 0; c < 200 && bidx[1] < 20; c++) step();
    n_chk++;
    if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) $display("FAIL rstmid_pre got vld=%b busy=%b want 1/1", m_axis_tvalid, busy);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    outs = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, s_axis_tready, busy, grant_idx};
    n_chk++;
    if (outs !== 32'd0) $display("FAIL rstmid_async_outs got %h want 0", outs);
    else n_pass++;
    setup_src(1, 0, 64);
    setup_src(0, 1, 8);
    setup_src(2, 1, 8);
    clear_mon();
    repeat (5) step();
    rst = 1'b1;
    for (int c = 0; c < 100 && d_code < 32'h10; c++) step();
    exp = {0, 2};
    n_chk++;
    if (g_code !== 32'h13 || d_code !== 32'h13) $display("FAIL rstmid_grants got g=%h d=%h want 13/13", g_code, d_code);
    else n_pass++;
    n_chk++;
    if (stream_errs(exp, 8) !== 0 || gap_errs(8) !== 0) $display("FAIL rstmid_stream got %0d bad beats %0d bad gaps want 0/0", stream_errs(exp, 8), gap_errs(8));
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int exp[$];
    clear_mon();
    for (int p = 0; p < 4; p++) setup_src(p, 0, 64);
    setup_src(3, 1, 64);
    tog = 1'b1;
    for (int c = 0; c < 400 && d_code == 0; c++) step();
    tog = 1'b0;
    exp = {3};
    n_chk++;
    if (g_code !== 32'h4 || d_code !== 32'h4) $display("FAIL bp_grants got g=%h d=%h want 4/4", g_code, d_code);
    else n_pass++;
    n_chk++;
    if (stream_errs(exp, 64) !== 0) $display("FAIL bp_stream got %0d bad beats want 0", stream_errs(exp, 64));
    else n_pass++;
    n_chk++;
    if (mirror_bad !== 0) $display("FAIL bp_ready_mirror got %0d mismatching cycles want 0", mirror_bad);
    else n_pass++;
  endtask

`ifdef AXIS_TX_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int errs;
    clear_mon();
    for (int p = 0; p < 4; p++) setup_src(p, 0, 64);
    setup_src(0, 1, 64);
    setup_src(1, 1, 8);
    for (int c = 0; c < 600 && (d_code == 0 || frm[0] == 0); c++) begin
      hold[0] = (bidx[0] == 30 && frm[0] == 0 && !inj_seen);
      step();
    end
    errs = 0;
    for (int b = 0; b < 30; b++)
      if (b >= b_dat.size() || b_dat[b] !== dat(0, 0, b) || b_last[b] !== 1'b0) errs++;
    if (b_dat.size() < 39 || b_dat[30] !== 8'h00 || b_last[30] !== 1'b1 || b_user[30] !== 1'b1) errs++;
    for (int b = 0; b < 8; b++)
      if (31 + b >= b_dat.size() || b_dat[31+b] !== dat(1, 0, b) || b_last[31+b] !== (b == 7)) errs++;
    n_chk++;
    if (errs !== 0 || b_dat.size() !== 39) $display("FAIL to_stream got %0d bad beats, %0d beats want 0, 39", errs, b_dat.size());
    else n_pass++;
    n_chk++;
    if (g_code !== 32'h12 || d_code !== 32'h2) $display("FAIL to_grants got g=%h d=%h want 12/2", g_code, d_code);
    else n_pass++;
    n_chk++;
    if (abort_cnt !== 16'd1 || frm[0] !== 1) $display("FAIL to_abort_sink got cnt=%0d frames=%0d want 1/1", abort_cnt, frm[0]);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_late_requester();
    test_reset_mid();
    test_backpressure();
`ifdef AXIS_TX_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_tx_arbiter.md
Name: axis_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single GMII TX datapath (8-bit AXI-Stream into the GMII MAC wrapper) between NUM_PORTS traffic sources, e.g. generator, ARP/ICMP responder and CPU injection.
- Grant is held from the first beat to the tlast beat, so frames are never interleaved.
- Sits directly upstream of the MAC s_axis port in the clk domain.

Parameters:
- NUM_PORTS, 4, number of requesting streams (2..8)
- USER_WIDTH, 1, tuser width, matches MAC
- TIMEOUT_CYCLES, 64, mid-packet stall limit (used only with the optional feature)

Ports:
- clk  in  1  MAC clock, all logic rising-edge
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- s_axis_tdata  in  NUM_PORTS*8  per-port data, port i at [8i+7:8i]
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tready  out  NUM_PORTS  per-port ready
- s_axis_tlast  in  NUM_PORTS  per-port last
- s_axis_tuser  in  NUM_PORTS*USER_WIDTH  per-port user (bit0 = bad frame)
- m_axis_tdata  out  8  to MAC
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- m_axis_tuser  out  USER_WIDTH
- grant_idx  out  $clog2(NUM_PORTS)  currently or last granted port
- busy  out  1  high while in XFER or DRAIN
- pkt_done  out  NUM_PORTS  one-cycle pulse per completed packet, per port

Behaviour:
- Reset state (rst=0, asynchronous): state=IDLE, rr pointer=NUM_PORTS-1 (port 0 wins first), grant_idx=0, busy=0, all s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, pkt_done=0.
- State IDLE:
  - Request vector = s_axis_tvalid.
  - If nonzero, the winner is the first set bit searching upward from rr pointer+1, with wrap-around.
  - Register grant_idx=winner, then go to XFER next cycle.
  - Latency: one cycle from tvalid rise to m_axis_tvalid.
- State XFER:
  - m_axis_{tdata,tvalid,tlast,tuser} = selected port's signals, combinationally muxed by the registered grant_idx.
  - s_axis_tready[grant_idx] = m_axis_tready; all other tready bits are 0.
  - A beat transfers when m_axis_tvalid and m_axis_tready are both high.
  - On a beat with tlast: pulse pkt_done[grant_idx], set rr pointer=grant_idx, return to IDLE. This leaves one idle bubble cycle between packets, which the MAC's IFG absorbs.
- Fairness: with all ports continuously requesting, the grant order is 0,1,2,3,0,...
- Non-requesting ports are skipped with no extra cycles.
- A single requester always wins, including immediate re-grant to itself.
- tvalid deasserting mid-packet on the granted port: the grant is held and m_axis_tvalid drops. No other port may be granted until tlast.
- A requester appearing during XFER waits. It is evaluated at the next IDLE cycle.
- Reset mid-packet: the output is truncated immediately and the MAC flags underflow; this is accepted behaviour. After reset, arbitration restarts from port 0.
- busy=1 exactly in XFER/DRAIN.
- Width: grant_idx is $clog2(NUM_PORTS) bits; the rr pointer wraps modulo NUM_PORTS.

Optional Feature:
- Macro: AXIS_TX_ARBITER_TIMEOUT_EN.
- With the macro: a stall counter runs in XFER.
  - The counter clears on any granted-port beat and increments on cycles where the granted tvalid=0.
  - When the count reaches TIMEOUT_CYCLES, the arbiter goes to state ABORT.
- State ABORT:
  - Present one injected beat: tdata=0, tlast=1, tuser=all ones, with s_axis_tready all 0.
  - When that beat is accepted, go to DRAIN.
- State DRAIN:
  - s_axis_tready[grant_idx]=1 and m_axis_tvalid=0; the remaining beats are discarded.
  - On a discarded tlast beat: rr pointer=grant_idx, then IDLE.
  - pkt_done is not pulsed for aborted packets.
- An extra output abort_cnt (16 bits) counts aborts and saturates at 0xFFFF.
- Without the macro: no counter, no ABORT/DRAIN states, no abort_cnt port, and stalls are held indefinitely.

Decomposition:
- Package axis_tx_arbiter_pkg holds:
  - the state enum (IDLE, XFER, ABORT, DRAIN)
  - localparam PORT_IDX_W function
  - the abort-beat constants
- One sub-module: rr_pick. It is combinational: the rotate, priority-encode and unrotate of the request vector against the rr pointer, returning winner index and any_req. It is reusable by the RX-side dispatcher.

Test Plan:
- All 4 ports each offer two 64-byte frames from t=0, with m_axis_tready=1 → grant order 0,1,2,3,0,1,2,3. Each packet is contiguous on m_axis with tlast on byte 64. There is one idle cycle between packets, and pkt_done pulses in matching order.
- Only port 2 requests, sending three back-to-back 60-byte frames → three grants to port 2. The ports 0/1/3 tready bits stay 0 throughout.
- Port 1 is granted, then port 0 raises tvalid at byte 10 → port 0 is not granted until port 1's tlast. The next grant is port 0 (wrap from pointer 1 → 2,3,0 order, with only 0 requesting).
- m_axis_tready toggles 1,0,1,0 during a 64-byte frame from port 3 → no data loss or duplication, and s_axis_tready[3] mirrors m_axis_tready exactly.
- rst driven to 0 at byte 20 of port 1's frame, released 5 cycles later → all outputs are 0 asynchronously, and the first post-reset grant goes to the lowest requesting port.
- Timeout (macro on, TIMEOUT_CYCLES=64): port 0 stalls 64 cycles at byte 30 → one injected beat with tdata=0, tlast=1, tuser=1. The remaining 34 bytes are sunk, abort_cnt=1, there is no pkt_done[0], and port 1 is granted next.
